operand_entry_sequencer: RTL and testbench

//   Upstream operand-entry stage for the board-level adder wrappers. Debounces a raw

---
 rtl/operand_entry_sequencer_if.sv | 26 ++
 rtl/operand_entry_sequencer.sv | 126 ++++++++++++
 tb/tb_operand_entry_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/operand_entry_sequencer_if.sv
// Operand-entry bus: raw button and switch inputs, captured operands and a valid/ready handshake.
interface operand_entry_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             key_n;
    logic [WIDTH-1:0] sw_data;
    logic             sw_carry;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             carry_in;
    logic             operands_valid;
    logic             operands_ready;
    logic [1:0]       state;

    // Sequencer side
    modport master (
        input  key_n, sw_data, sw_carry, operands_ready,
        output x, y, carry_in, operands_valid, state
    );

    // Board / downstream side
    modport slave (
        output key_n, sw_data, sw_carry, operands_ready,
        input  x, y, carry_in, operands_valid, state
    );
endinterface

// File: rtl/operand_entry_sequencer.sv
// Operand-entry sequencer: debounces an active-low push-button and steps through
// X capture, Y/carry capture and a valid/ready hand-off to the adder stage.
module operand_entry_sequencer #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input logic                      clock,
    input logic                      reset,
    operand_entry_sequencer_if.master bus
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StLoadX = 2'b00,
        StLoadY = 2'b01,
        StValid = 2'b10
    } state_e;

    logic          sync1_q, sync2_q;
    logic          debounced_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             carry_q, carry_d;
    logic             valid_q, valid_d;

    // Two-flop synchroniser for the asynchronous button; idles at released (1).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.key_n;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a level only after DEBOUNCE_CYCLES consecutive differing samples;
    // a falling debounced level registers a one-cycle press pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            debounced_q <= 1'b1;
            cnt_q       <= '0;
            press_q     <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (sync2_q == debounced_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
                debounced_q <= sync2_q;
                cnt_q       <= '0;
                press_q     <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // FSM and operand registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StLoadX;
            x_q     <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    // Next-state: capture switches on press, hold the set in VALID until accepted.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        carry_d = carry_q;
        valid_d = valid_q;
        case (state_q)
            StLoadX: begin
                valid_d = 1'b0;
                if (press_q) begin
                    x_d     = bus.sw_data;
                    state_d = StLoadY;
                end
            end
            StLoadY: begin
                valid_d = 1'b0;
                if (press_q) begin
                    y_d     = bus.sw_data;
                    carry_d = bus.sw_carry;
                    valid_d = 1'b1;
                    state_d = StValid;
                end
            end
            StValid: begin
                valid_d = 1'b1;
                if (valid_q && bus.operands_ready) begin
                    valid_d = 1'b0;
                    state_d = StLoadX;
                end
            end
            default: begin
                // Encoding 11 is unreachable; recover cleanly.
                valid_d = 1'b0;
                state_d = StLoadX;
            end
        endcase
    end

    assign bus.x              = x_q;
    assign bus.y              = y_q;
    assign bus.carry_in       = carry_q;
    assign bus.operands_valid = valid_q;
    assign bus.state          = state_q;

endmodule

// File: tb/tb_operand_entry_sequencer.sv
// Directed bench for operand_entry_sequencer with DEBOUNCE_CYCLES=4, WIDTH=8.
module tb_operand_entry_sequencer;

    logic clock;
    logic reset;
    int   pass_cnt;
    int   fail_cnt;
    int   total;

    operand_entry_sequencer_if #(.WIDTH(8)) bus_if ();

    operand_entry_sequencer #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clean press: low for n_low edges, then released long enough to re-debounce high.
    task automatic press(input int n_low);
        bus_if.key_n = 1'b0;
        tick(n_low);
        bus_if.key_n = 1'b1;
        tick(12);
    endtask

    initial begin
        pass_cnt = 0;
        fail_cnt = 0;
        total    = 0;
        reset    = 1'b1;
        bus_if.key_n          = 1'b1;
        bus_if.sw_data        = 8'h00;
        bus_if.sw_carry       = 1'b0;
        bus_if.operands_ready = 1'b0;

        // 1. Reset values
        tick(2);
        check("rst_x", 32'(bus_if.x), 32'h0);
        check("rst_y", 32'(bus_if.y), 32'h0);
        check("rst_carry", 32'(bus_if.carry_in), 32'h0);
        check("rst_valid", 32'(bus_if.operands_valid), 32'h0);
        check("rst_state", 32'(bus_if.state), 32'h0);
        reset = 1'b0;
        tick(3);

        // 2. Clean press: capture exactly 7 edges after key_n goes low
        bus_if.sw_data = 8'h3C;
        bus_if.key_n   = 1'b0;
        tick(6);
        check("lat6_state", 32'(bus_if.state), 32'h0);
        check("lat6_x", 32'(bus_if.x), 32'h0);
        tick(1);
        check("lat7_x", 32'(bus_if.x), 32'h3C);
        check("lat7_state", 32'(bus_if.state), 32'h1);
        tick(100);
        check("held_state", 32'(bus_if.state), 32'h1);
        bus_if.key_n = 1'b1;
        tick(12);
        check("release_state", 32'(bus_if.state), 32'h1);

        // 3. Short glitches: no event
        bus_if.sw_data = 8'h99;
        bus_if.key_n = 1'b0; tick(3);
        bus_if.key_n = 1'b1; tick(1);
        bus_if.key_n = 1'b0; tick(2);
        bus_if.key_n = 1'b1; tick(12);
        check("glitch_state", 32'(bus_if.state), 32'h1);
        check("glitch_y", 32'(bus_if.y), 32'h0);
        // 5-cycle pulse: exactly one event (LOAD_Y -> VALID)
        bus_if.sw_data  = 8'h11;
        bus_if.sw_carry = 1'b0;
        press(5);
        check("pulse5_state", 32'(bus_if.state), 32'h2);
        check("pulse5_y", 32'(bus_if.y), 32'h11);
        check("pulse5_valid", 32'(bus_if.operands_valid), 32'h1);
        bus_if.operands_ready = 1'b1; tick(1);
        bus_if.operands_ready = 1'b0;
        check("accept1_state", 32'(bus_if.state), 32'h0);
        check("accept1_valid", 32'(bus_if.operands_valid), 32'h0);

        // 4. Full sequence with ready low
        bus_if.sw_data = 8'hA5;
        press(6);
        check("seq_x_state", 32'(bus_if.state), 32'h1);
        check("seq_x", 32'(bus_if.x), 32'hA5);
        bus_if.sw_data  = 8'h5A;
        bus_if.sw_carry = 1'b1;
        press(6);
        check("seq_valid", 32'(bus_if.operands_valid), 32'h1);
        check("seq_state", 32'(bus_if.state), 32'h2);
        check("seq_x2", 32'(bus_if.x), 32'hA5);
        check("seq_y", 32'(bus_if.y), 32'h5A);
        check("seq_carry", 32'(bus_if.carry_in), 32'h1);
        // Presses and switch changes in VALID are ignored
        bus_if.sw_data  = 8'h00;
        bus_if.sw_carry = 1'b0;
        press(6);
        check("vld_ign_x", 32'(bus_if.x), 32'hA5);
        check("vld_ign_y", 32'(bus_if.y), 32'h5A);
        check("vld_ign_carry", 32'(bus_if.carry_in), 32'h1);
        check("vld_ign_state", 32'(bus_if.state), 32'h2);
        bus_if.operands_ready = 1'b1; tick(1);
        bus_if.operands_ready = 1'b0;
        check("accept2_valid", 32'(bus_if.operands_valid), 32'h0);
        check("accept2_state", 32'(bus_if.state), 32'h0);
        check("persist_x", 32'(bus_if.x), 32'hA5);
        check("persist_y", 32'(bus_if.y), 32'h5A);

        // 5. All-ones operands with ready held high
        bus_if.operands_ready = 1'b1;
        bus_if.sw_data  = 8'hFF;
        press(6);
        check("ff_x", 32'(bus_if.x), 32'hFF);
        bus_if.sw_carry = 1'b1;
        bus_if.key_n = 1'b0;
        tick(7);
        check("ff_valid_on", 32'(bus_if.operands_valid), 32'h1);
        check("ff_y", 32'(bus_if.y), 32'hFF);
        check("ff_carry", 32'(bus_if.carry_in), 32'h1);
        tick(1);
        check("ff_valid_off", 32'(bus_if.operands_valid), 32'h0);
        check("ff_state", 32'(bus_if.state), 32'h0);
        bus_if.key_n = 1'b1;
        tick(12);
        check("ff_valid_stays", 32'(bus_if.operands_valid), 32'h0);
        check("ff_x_keep", 32'(bus_if.x), 32'hFF);

        // 6. Ready in LOAD_X is ignored
        bus_if.operands_ready = 1'b1; tick(3);
        bus_if.operands_ready = 1'b0;
        check("rdy_lx_state", 32'(bus_if.state), 32'h0);
        check("rdy_lx_valid", 32'(bus_if.operands_valid), 32'h0);
        // Switches toggling during debounce: capture-edge value wins
        bus_if.key_n   = 1'b0;
        bus_if.sw_data = 8'h01; tick(3);
        bus_if.sw_data = 8'h02; tick(3);
        bus_if.sw_data = 8'h77; tick(1);
        check("tog_x", 32'(bus_if.x), 32'h77);
        bus_if.sw_data = 8'h00;
        tick(1);
        check("tog_x_hold", 32'(bus_if.x), 32'h77);
        bus_if.key_n = 1'b1;
        tick(12);
        bus_if.sw_data  = 8'h12;
        bus_if.sw_carry = 1'b1;
        press(6);
        check("pre_rst_state", 32'(bus_if.state), 32'h2);
        // Asynchronous reset in VALID: outputs clear with no clock edge
        reset = 1'b1;
        #2;
        check("arst_x", 32'(bus_if.x), 32'h0);
        check("arst_y", 32'(bus_if.y), 32'h0);
        check("arst_carry", 32'(bus_if.carry_in), 32'h0);
        check("arst_valid", 32'(bus_if.operands_valid), 32'h0);
        check("arst_state", 32'(bus_if.state), 32'h0);
        tick(2);
        reset = 1'b0;
        tick(5);
        check("post_rst_state", 32'(bus_if.state), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
